// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage in-order pipeline: load-use, mul/div occupancy,
// data-memory wait states and branch/jump redirect squashing of IF/ID.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_md_start,
    input  logic              md_done,
    input  logic              ex_redirect,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_stall,
    output logic              if_stall,
    output logic              if_flush,
    output logic              idex_bubble,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cnt
);
    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] MD_WAIT    = 2'd1;
    localparam logic [1:0] MEM_WAIT   = 2'd2;
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES);

    logic [1:0]        state_reg, state_next;
    logic [1:0]        ret_reg, ret_next;
    logic              md_sticky_reg, md_sticky_next;
    logic              pending_flush_reg, pending_flush_next;
    logic [1:0]        flush_cnt_reg, flush_cnt_next;
    logic [PERF_W-1:0] stall_cnt_reg;

    logic       mem_hold;
    logic       load_use;
    logic       lu_stall;
    logic       hold_front;
    logic       flush_now;
    logic [1:0] flush_eff;

    assign mem_hold = mem_req && !mem_ready;

    assign load_use = (state_reg == RUN) && ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // A redirect takes effect in its own cycle; otherwise any flush still owed is replayed.
    assign flush_eff = ex_redirect       ? FLUSH_LOAD :
                       pending_flush_reg ? flush_cnt_reg : 2'd0;

    // The ID instruction is wrong-path while a flush is owed, so it must not stall the front end.
    assign lu_stall   = load_use && (flush_eff == 2'd0);
    assign hold_front = (state_reg != RUN) || lu_stall;
    assign flush_now  = (flush_eff != 2'd0) && !hold_front;

    assign flush_cnt_next     = flush_now ? (flush_eff - 2'd1) : flush_eff;
    assign pending_flush_next = (flush_cnt_next != 2'd0);

    always_comb begin
        state_next     = state_reg;
        ret_next       = ret_reg;
        md_sticky_next = md_sticky_reg;
        case (state_reg)
            RUN: begin
                if (mem_hold) begin
                    state_next     = MEM_WAIT;
                    ret_next       = ex_md_start ? MD_WAIT : RUN;
                    md_sticky_next = 1'b0;
                end else if (ex_md_start) begin
                    state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (mem_hold) begin
                    state_next     = MEM_WAIT;
                    ret_next       = MD_WAIT;
                    md_sticky_next = md_done;
                end else if (md_done) begin
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (!mem_hold) begin
                    // A mul/div that finished under the memory wait must not cost an extra cycle.
                    state_next     = ((ret_reg == MD_WAIT) && !md_sticky_reg && !md_done) ? MD_WAIT : RUN;
                    ret_next       = RUN;
                    md_sticky_next = 1'b0;
                end else if (md_done) begin
                    md_sticky_next = 1'b1;
                end
            end
            default: begin
                state_next     = RUN;
                ret_next       = RUN;
                md_sticky_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= RUN;
            ret_reg           <= RUN;
            md_sticky_reg     <= 1'b0;
            pending_flush_reg <= 1'b0;
            flush_cnt_reg     <= 2'd0;
            stall_cnt_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            ret_reg           <= ret_next;
            md_sticky_reg     <= md_sticky_next;
            pending_flush_reg <= pending_flush_next;
            flush_cnt_reg     <= flush_cnt_next;
            if (hold_front) begin
                stall_cnt_reg <= stall_cnt_reg + {{(PERF_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Controls are forced quiet for the whole time reset is held, not just after the edge.
    assign pc_stall    = rst && hold_front;
    assign if_stall    = rst && hold_front;
    assign if_flush    = rst && flush_now;
    assign idex_bubble = rst && load_use;
    assign ex_stall    = rst && (state_reg != RUN);
    assign mem_stall   = rst && (state_reg == MEM_WAIT);
    assign busy        = (state_reg != RUN);
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage in-order RV64 pipeline.
- Drives the hold and flush controls of the PC register, the IF/ID register, the ID/EX register and the EX/MEM register.
- Resolves load-use hazards, multi-cycle mul/div occupancy, data-memory wait states and branch/jump redirects.
- Guarantees that the IF/ID register's stall-over-flush priority never drops a redirect squash.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed after a redirect (1..3; covers multi-stage fetch latency).
- PERF_W, 64, width of the stall-cycle performance counter.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-low reset
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  destination register of the instruction in EX
- ex_is_load  input  1  EX instruction is a load
- ex_md_start  input  1  EX launches a mul/div this cycle
- md_done  input  1  mul/div result valid (one-cycle pulse)
- ex_redirect  input  1  EX resolved a taken branch/jump or mispredict
- mem_req  input  1  MEM stage has an outstanding data access
- mem_ready  input  1  data memory completes the access this cycle
- pc_stall  output  1  hold PC
- if_stall  output  1  hold IF/ID (stall input of IF/ID register)
- if_flush  output  1  squash IF/ID to NOP 0x00000013
- idex_bubble  output  1  load a bubble into ID/EX
- ex_stall  output  1  hold ID/EX
- mem_stall  output  1  hold EX/MEM
- busy  output  1  FSM not in RUN
- stall_cnt  output  PERF_W  count of cycles with pc_stall=1

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN.
  - pending_flush=0, flush_cnt=0, stall_cnt=0.
  - All control outputs are 0.
- States:
  - RUN: normal operation.
  - MD_WAIT: mul/div occupying EX.
  - MEM_WAIT: data access outstanding.
- Transitions (priority order):
  - MEM_WAIT: entered from any state when mem_req=1 and mem_ready=0. Held until mem_ready=1, then return to the state that preempted it, or RUN.
  - MD_WAIT: entered from RUN when ex_md_start=1. Exits to RUN in the cycle md_done=1.
  - md_done arriving while in MEM_WAIT is latched in a sticky flag and consumed on MEM_WAIT exit.
- Output decode:
  - MEM_WAIT: pc_stall=if_stall=ex_stall=mem_stall=1.
  - MD_WAIT: pc_stall=if_stall=ex_stall=1, mem_stall=0. EX/MEM receives a bubble from the EX stage itself.
  - RUN load-use (ex_is_load=1, ex_rd!=0, ex_rd matches an used ID source): pc_stall=if_stall=1 and idex_bubble=1 for exactly one cycle.
  - Register x0 never creates a hazard.
- Redirect handling:
  - ex_redirect=1 loads flush_cnt=FLUSH_CYCLES.
  - if_flush=1 while flush_cnt!=0 and if_stall=0; flush_cnt decrements only on those cycles.
  - If a redirect arrives while if_stall=1, it is held in pending_flush/flush_cnt and asserted on the first non-stalled cycle. Never dropped.
  - A redirect in the same cycle as a load-use condition: the redirect wins. No load-use stall; if_flush=1 and idex_bubble=1 (wrong-path ID instruction squashed).
  - A new redirect while flush_cnt!=0 reloads flush_cnt to FLUSH_CYCLES.
- Invariants:
  - if_flush and if_stall are never both 1.
  - idex_bubble and ex_stall are never both 1.
- Counter:
  - stall_cnt increments on every cycle with pc_stall=1.
  - Wraps modulo 2^PERF_W.
- Latency: all outputs are combinational from current state plus inputs. State updates on the rising edge of clk.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_stall=if_stall=idex_bubble=1, then all 0; with ex_rd=0 -> no stall.
- Mul/div: ex_md_start=1, md_done 4 cycles later -> busy and ex_stall high exactly 4 cycles, RUN on the md_done cycle, stall_cnt=4.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles during MD_WAIT, md_done inside the window -> all four stalls high 3 cycles, RUN on MEM_WAIT exit, no extra MD_WAIT cycle.
- Redirect during stall: ex_redirect pulse while MEM_WAIT -> if_flush=0 while stalled, if_flush=1 exactly FLUSH_CYCLES cycles after mem_ready.
- Redirect plus load-use in the same cycle -> if_flush=1, idex_bubble=1, pc_stall=0.
- Async reset asserted mid-MD_WAIT (between clock edges) -> outputs 0 immediately, stall_cnt=0, RUN after release.
